// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only data memory: alignment/range check,
// read-modify-write for sub-word stores, byte/half extraction with sign/zero extension.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_ena,
  output logic        dm_r,
  output logic        dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Upper bound kept in 33 bits so a region ending at 4 GiB cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  // Handshake: a request transfers on the posedge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no backpressure.

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic        r_err;

  logic        w_accept;
  logic        w_bad_size;
  logic        w_misalign;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_load_val;
  logic [31:0] w_lane_mask;
  logic [31:0] w_store_word;

  assign w_accept       = req_valid && (r_state == S_IDLE);
  assign w_bad_size     = (req_size == 2'b11);
  assign w_misalign     = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) ||
                          ({1'b0, req_addr} >= END_ADDR);
  assign w_req_err      = w_bad_size || w_misalign || w_out_of_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'h0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= req_addr;
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
        r_err      <= w_req_err;
      end
      if (r_state == S_RD) r_word <= dm_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                w_next = S_RESP;
          else if (!req_we)             w_next = S_RD;
          else if (req_size == 2'b10)   w_next = S_WR;
          else                          w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane selection: little-endian, byte lane = addr[1:0]; a halfword's addr[0] is 0.
  assign w_shamt   = {r_addr[1:0], 3'b000};
  assign w_shifted = r_word >> w_shamt;

  always_comb begin
    w_load_val  = r_word;
    w_lane_mask = 32'hFFFF_FFFF;
    case (r_size)
      2'b00: begin
        w_load_val  = r_unsigned ? {24'h0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
        w_lane_mask = 32'h0000_00FF << w_shamt;
      end
      2'b01: begin
        w_load_val  = r_unsigned ? {16'h0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
        w_lane_mask = 32'h0000_FFFF << w_shamt;
      end
      default: begin
        w_load_val  = r_word;
        w_lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // For SW the mask is all-ones, so the merge reduces to the store data itself.
  assign w_store_word = (r_word & ~w_lane_mask) | ((r_wdata << w_shamt) & w_lane_mask);

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    dm_ena     = 1'b0;
    dm_r       = 1'b0;
    dm_w       = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_RD: begin
        dm_ena  = 1'b1;
        dm_r    = 1'b1;
        dm_addr = {r_addr[31:2], 2'b00};
      end
      S_WR: begin
        dm_ena   = 1'b1;
        dm_w     = 1'b1;
        dm_addr  = {r_addr[31:2], 2'b00};
        dm_wdata = w_store_word;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_we) resp_rdata = w_load_val;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads/stores, error cases, reset abort, back-to-back.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_ena;
  logic        dm_r;
  logic        dm_w;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_ena(dm_ena), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  // data memory model: combinational read, posedge write
  logic [31:0] mem [0:2047];
  logic [31:0] w_off;
  assign w_off    = dm_addr - BASE;
  assign dm_rdata = (w_off < 32'h2000) ? mem[w_off[12:2]] : 32'h0;

  always @(posedge clk) begin
    if (dm_ena && dm_w && (w_off < 32'h2000)) mem[w_off[12:2]] <= dm_wdata;
  end

  // bus activity monitors, sampled mid-cycle
  int cnt_ena = 0, cnt_r = 0, cnt_w = 0, cnt_resp = 0, cnt_both = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_addr = 32'h0;
  always @(negedge clk) begin
    if (dm_ena) cnt_ena++;
    if (dm_r) cnt_r++;
    if (dm_w) begin cnt_w++; last_wdata = dm_wdata; end
    if (dm_ena) last_addr = dm_addr;
    if (resp_valid) cnt_resp++;
    if (dm_r && dm_w) cnt_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: issue one request, wait (bounded) for the response, check it
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int s_ena, s_r, s_w;
    int exp_r, exp_w;
    logic ready_low;
    exp_r = (!exp_err && (!we || sz != 2'b10)) ? 1 : 0;
    exp_w = (!exp_err && we) ? 1 : 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    chk({tag, "_ready_idle"}, {31'h0, req_ready}, 32'h1);
    s_ena = cnt_ena; s_r = cnt_r; s_w = cnt_w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    ready_low = 1'b1;
    while (!resp_valid && lat < 8) begin
      if (req_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    chk({tag, "_ready_busy"}, {31'h0, ready_low & ~req_ready}, 32'h1);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_n_rd"}, cnt_r - s_r, exp_r);
    chk({tag, "_n_wr"}, cnt_w - s_w, exp_w);
    chk({tag, "_n_ena"}, cnt_ena - s_ena, exp_r + exp_w);
    if (!exp_err) chk({tag, "_dm_addr"}, last_addr, {addr[31:2], 2'b00});
  endtask

  initial begin
    int s_w, s_resp;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[0] = 32'h8899AABB;

    // reset state
    #2;
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_dm_ena", {31'h0, dm_ena}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);

    // word and sub-word loads
    do_req("lw0",  1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, 2, 32'h8899AABB, 1'b0);
    do_req("lb1",  1'b0, 2'b00, 1'b0, 32'h10010001, 32'h0, 2, 32'hFFFFFFAA, 1'b0);
    do_req("lbu1", 1'b0, 2'b00, 1'b1, 32'h10010001, 32'h0, 2, 32'h000000AA, 1'b0);
    do_req("lh2",  1'b0, 2'b01, 1'b0, 32'h10010002, 32'h0, 2, 32'hFFFF8899, 1'b0);
    do_req("lhu2", 1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0, 2, 32'h00008899, 1'b0);
    do_req("lbu0", 1'b0, 2'b00, 1'b1, 32'h10010000, 32'h0, 2, 32'h000000BB, 1'b0);

    // sub-word store via read-modify-write
    do_req("sb2", 1'b1, 2'b00, 1'b0, 32'h10010002, 32'h123456CC, 3, 32'h0, 1'b0);
    chk("sb2_dm_wdata", last_wdata, 32'h88CCAABB);
    do_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, 2, 32'h88CCAABB, 1'b0);

    // halfword store to the last word of memory, then read back
    do_req("sh_top", 1'b1, 2'b01, 1'b0, 32'h10011FFE, 32'hFFFF8765, 3, 32'h0, 1'b0);
    chk("sh_top_dm_wdata", last_wdata, 32'h87650000);
    do_req("lh_top", 1'b0, 2'b01, 1'b0, 32'h10011FFE, 32'h0, 2, 32'hFFFF8765, 1'b0);

    // error cases
    do_req("e_lw_mis", 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, 1, 32'h0, 1'b1);
    do_req("e_sh_mis", 1'b1, 2'b01, 1'b0, 32'h10010001, 32'h5555, 1, 32'h0, 1'b1);
    do_req("e_lw_hi",  1'b0, 2'b10, 1'b0, 32'h10012000, 32'h0, 1, 32'h0, 1'b1);
    do_req("e_lw_lo",  1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0, 1, 32'h0, 1'b1);
    do_req("e_size",   1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0, 1, 32'h0, 1'b1);

    // reset during the RD cycle of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10010000; req_wdata = 32'h00001234;
    s_w = cnt_w; s_resp = cnt_resp;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_rd", {30'h0, dbg_state}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dm_ena", {31'h0, dm_ena}, 32'h0);
    chk("abort_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_wr", cnt_w - s_w, 32'h0);
    chk("abort_no_resp", cnt_resp - s_resp, 32'h0);
    chk("abort_mem", mem[0], 32'h88CCAABB);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);

    // back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10010004; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h10010004; req_wdata = 32'h0;
    chk("b2b_wr_state", {30'h0, dbg_state}, 32'h2);
    chk("b2b_wr_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_sw_resp", {31'h0, resp_valid}, 32'h1);
    chk("b2b_resp_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("b2b_mem", mem[1], 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_rd_ready", {31'h0, req_ready}, 32'h0);
    chk("b2b_rd_state", {30'h0, dbg_state}, 32'h1);
    @(posedge clk); #1;
    chk("b2b_lw_resp", {31'h0, resp_valid}, 32'h1);
    chk("b2b_lw_rdata", resp_rdata, 32'hDEADBEEF);

    chk("rd_wr_exclusive", cnt_both, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
